stg_mem: RTL and testbench

STG_MEM -- requirements
Module: stg_mem

---
 rtl/stg_mem.sv | 179 +++++++++++++++++
 tb/tb_stg_mem.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/stg_mem.sv
// Memory pipeline stage: passes non-memory ops through in one cycle and runs loads/stores through a request/ack handshake.
// Optional feature: define MEM_TIMEOUT_EN to abort requests left unacknowledged for 16 cycles.
`ifndef SIZE_ADDR
`define SIZE_ADDR 24
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 24
`endif
`ifndef SIZE_OPC
`define SIZE_OPC 8
`endif
`ifndef SIZE_TGT_GP
`define SIZE_TGT_GP 4
`endif
`ifndef SIZE_TGT_SR
`define SIZE_TGT_SR 2
`endif
`ifndef OPC_RU_LDu
`define OPC_RU_ADDu 8'h01
`define OPC_RU_LDu  8'h10
`define OPC_RU_STu  8'h11
`define OPC_IU_STiu 8'h12
`define OPC_IS_STis 8'h13
`endif

module stg_mem (
    input  logic                    iw_clk,
    input  logic                    iw_rst,
    input  logic [`SIZE_ADDR-1:0]   iw_pc,
    output logic [`SIZE_ADDR-1:0]   ow_pc,
    input  logic [`SIZE_DATA-1:0]   iw_instr,
    output logic [`SIZE_DATA-1:0]   ow_instr,
    input  logic [`SIZE_OPC-1:0]    iw_opc,
    output logic [`SIZE_OPC-1:0]    ow_opc,
    input  logic [`SIZE_TGT_GP-1:0] iw_tgt_gp,
    input  logic                    iw_tgt_gp_we,
    output logic [`SIZE_TGT_GP-1:0] ow_tgt_gp,
    output logic                    ow_tgt_gp_we,
    input  logic [`SIZE_TGT_SR-1:0] iw_tgt_sr,
    input  logic                    iw_tgt_sr_we,
    output logic [`SIZE_TGT_SR-1:0] ow_tgt_sr,
    output logic                    ow_tgt_sr_we,
    input  logic [`SIZE_ADDR-1:0]   iw_addr,
    input  logic [`SIZE_DATA-1:0]   iw_result,
    output logic [`SIZE_DATA-1:0]   ow_result,
    output logic                    or_mem_req,
    output logic [`SIZE_ADDR-1:0]   ow_mem_addr,
    output logic                    ow_mem_we,
    output logic [`SIZE_DATA-1:0]   ow_mem_wdata,
    input  logic                    iw_mem_ack,
    input  logic [`SIZE_DATA-1:0]   iw_mem_rdata,
    output logic                    ow_stall,
    input  logic                    iw_stall,
    output logic                    or_mem_err
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t                 state_q, state_d;
    logic                   is_mem, is_store;
    logic                   issue, ack_ev, to_ev, fin, cmpl, buffer;
    logic                   pend_q, pend_err_q, cmpl_err;
    logic [`SIZE_DATA-1:0]  buf_q, cmpl_result;

    assign is_store = (iw_opc == `OPC_RU_STu) || (iw_opc == `OPC_IU_STiu) || (iw_opc == `OPC_IS_STis);
    assign is_mem   = is_store || (iw_opc == `OPC_RU_LDu);

    assign issue  = (state_q == IDLE) && is_mem && !iw_stall;
    assign ack_ev = (state_q == REQ) && !pend_q && iw_mem_ack;
    assign fin    = (state_q == REQ) && (ack_ev || to_ev || pend_q);
    assign cmpl   = fin && !iw_stall;
    assign buffer = (ack_ev || to_ev) && iw_stall;

`ifdef MEM_TIMEOUT_EN
    logic [3:0] cnt_q;
    assign to_ev = (state_q == REQ) && !pend_q && !iw_mem_ack && (cnt_q == 4'd15);

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            cnt_q      <= '0;
            or_mem_err <= 1'b0;
        end else begin
            if (issue)
                cnt_q <= '0;
            else if ((state_q == REQ) && !fin)
                cnt_q <= cnt_q + 4'd1;
            if (to_ev)
                or_mem_err <= 1'b1;
        end
    end
`else
    assign to_ev      = 1'b0;
    assign or_mem_err = 1'b0;
`endif

    // A buffered completion also releases upstream, otherwise a held memory op would be re-issued.
    assign ow_stall = issue || ((state_q == REQ) && !fin);

    always_comb begin
        state_d = state_q;
        if (issue)
            state_d = REQ;
        else if (cmpl)
            state_d = IDLE;
    end

    always_comb begin
        cmpl_err    = pend_q ? pend_err_q : to_ev;
        cmpl_result = '0;
        if (!cmpl_err)
            cmpl_result = ow_mem_we ? ow_mem_wdata : (pend_q ? buf_q : iw_mem_rdata);
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            or_mem_req   <= 1'b0;
            ow_mem_addr  <= '0;
            ow_mem_we    <= 1'b0;
            ow_mem_wdata <= '0;
            pend_q       <= 1'b0;
            pend_err_q   <= 1'b0;
            buf_q        <= '0;
        end else begin
            if (issue) begin
                or_mem_req   <= 1'b1;
                ow_mem_addr  <= iw_addr;
                ow_mem_we    <= is_store;
                ow_mem_wdata <= iw_result;
            end
            if (ack_ev || to_ev)
                or_mem_req <= 1'b0;
            if (buffer) begin
                pend_q     <= 1'b1;
                pend_err_q <= to_ev;
                buf_q      <= iw_mem_rdata;
            end
            if (cmpl) begin
                pend_q     <= 1'b0;
                pend_err_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            ow_pc        <= '0;
            ow_instr     <= '0;
            ow_opc       <= '0;
            ow_tgt_gp    <= '0;
            ow_tgt_gp_we <= 1'b0;
            ow_tgt_sr    <= '0;
            ow_tgt_sr_we <= 1'b0;
            ow_result    <= '0;
        end else if (!iw_stall) begin
            if (((state_q == IDLE) && !is_mem) || cmpl) begin
                ow_pc        <= iw_pc;
                ow_instr     <= iw_instr;
                ow_opc       <= iw_opc;
                ow_tgt_gp    <= iw_tgt_gp;
                ow_tgt_gp_we <= iw_tgt_gp_we && !(cmpl && cmpl_err);
                ow_tgt_sr    <= iw_tgt_sr;
                ow_tgt_sr_we <= iw_tgt_sr_we;
                ow_result    <= cmpl ? cmpl_result : iw_result;
            end else begin
                ow_opc       <= '0;
                ow_tgt_gp_we <= 1'b0;
                ow_tgt_sr_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stg_mem.sv
// Directed self-checking bench for stg_mem: pass-through, load/store handshakes, downstream stall, reset and timeout.
`ifndef SIZE_ADDR
`define SIZE_ADDR 24
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 24
`endif
`ifndef SIZE_OPC
`define SIZE_OPC 8
`endif
`ifndef SIZE_TGT_GP
`define SIZE_TGT_GP 4
`endif
`ifndef SIZE_TGT_SR
`define SIZE_TGT_SR 2
`endif
`ifndef OPC_RU_LDu
`define OPC_RU_ADDu 8'h01
`define OPC_RU_LDu  8'h10
`define OPC_RU_STu  8'h11
`define OPC_IU_STiu 8'h12
`define OPC_IS_STis 8'h13
`endif

module tb_stg_mem;

    logic                    iw_clk = 1'b0;
    logic                    iw_rst;
    logic [`SIZE_ADDR-1:0]   iw_pc, ow_pc;
    logic [`SIZE_DATA-1:0]   iw_instr, ow_instr;
    logic [`SIZE_OPC-1:0]    iw_opc, ow_opc;
    logic [`SIZE_TGT_GP-1:0] iw_tgt_gp, ow_tgt_gp;
    logic                    iw_tgt_gp_we, ow_tgt_gp_we;
    logic [`SIZE_TGT_SR-1:0] iw_tgt_sr, ow_tgt_sr;
    logic                    iw_tgt_sr_we, ow_tgt_sr_we;
    logic [`SIZE_ADDR-1:0]   iw_addr;
    logic [`SIZE_DATA-1:0]   iw_result, ow_result;
    logic                    or_mem_req;
    logic [`SIZE_ADDR-1:0]   ow_mem_addr;
    logic                    ow_mem_we;
    logic [`SIZE_DATA-1:0]   ow_mem_wdata;
    logic                    iw_mem_ack;
    logic [`SIZE_DATA-1:0]   iw_mem_rdata;
    logic                    ow_stall;
    logic                    iw_stall;
    logic                    or_mem_err;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned stalls;
    int unsigned n;

    always #5 iw_clk = ~iw_clk;

    stg_mem u_dut (
        .iw_clk       (iw_clk),
        .iw_rst       (iw_rst),
        .iw_pc        (iw_pc),
        .ow_pc        (ow_pc),
        .iw_instr     (iw_instr),
        .ow_instr     (ow_instr),
        .iw_opc       (iw_opc),
        .ow_opc       (ow_opc),
        .iw_tgt_gp    (iw_tgt_gp),
        .iw_tgt_gp_we (iw_tgt_gp_we),
        .ow_tgt_gp    (ow_tgt_gp),
        .ow_tgt_gp_we (ow_tgt_gp_we),
        .iw_tgt_sr    (iw_tgt_sr),
        .iw_tgt_sr_we (iw_tgt_sr_we),
        .ow_tgt_sr    (ow_tgt_sr),
        .ow_tgt_sr_we (ow_tgt_sr_we),
        .iw_addr      (iw_addr),
        .iw_result    (iw_result),
        .ow_result    (ow_result),
        .or_mem_req   (or_mem_req),
        .ow_mem_addr  (ow_mem_addr),
        .ow_mem_we    (ow_mem_we),
        .ow_mem_wdata (ow_mem_wdata),
        .iw_mem_ack   (iw_mem_ack),
        .iw_mem_rdata (iw_mem_rdata),
        .ow_stall     (ow_stall),
        .iw_stall     (iw_stall),
        .or_mem_err   (or_mem_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iw_clk);
        #1;
    endtask

    initial begin
        iw_rst = 1'b1;
        iw_pc = '0; iw_instr = '0; iw_opc = '0; iw_tgt_gp = '0; iw_tgt_gp_we = 1'b0;
        iw_tgt_sr = '0; iw_tgt_sr_we = 1'b0; iw_addr = '0; iw_result = '0;
        iw_mem_ack = 1'b0; iw_mem_rdata = '0; iw_stall = 1'b0;
        tick(); tick();
        chk("rst_req", 32'(or_mem_req), 32'h0);
        chk("rst_result", 32'(ow_result), 32'h0);
        chk("rst_opc", 32'(ow_opc), 32'h0);
        chk("rst_err", 32'(or_mem_err), 32'h0);
        chk("rst_stall", 32'(ow_stall), 32'h0);
        iw_rst = 1'b0;

        // ADDu pass-through
        iw_opc = `OPC_RU_ADDu; iw_result = 24'h000123; iw_tgt_gp_we = 1'b1; iw_tgt_gp = 4'd5; iw_pc = 24'h000100;
        #1;
        chk("add_stall_pre", 32'(ow_stall), 32'h0);
        tick();
        chk("add_result", 32'(ow_result), 32'h000123);
        chk("add_gp_we", 32'(ow_tgt_gp_we), 32'h1);
        chk("add_tgt_gp", 32'(ow_tgt_gp), 32'h5);
        chk("add_pc", 32'(ow_pc), 32'h000100);
        chk("add_stall", 32'(ow_stall), 32'h0);
        chk("add_req", 32'(or_mem_req), 32'h0);

        // LDu with ack in the 4th REQ cycle
        iw_opc = `OPC_RU_LDu; iw_addr = 24'h000040; iw_mem_rdata = 24'hABCDEF; iw_result = '0; iw_tgt_gp = 4'd3;
        #1;
        stalls = 0;
        if (ow_stall) stalls++;
        tick();
        chk("ld_req", 32'(or_mem_req), 32'h1);
        chk("ld_addr", 32'(ow_mem_addr), 32'h000040);
        chk("ld_we", 32'(ow_mem_we), 32'h0);
        chk("ld_bubble_opc", 32'(ow_opc), 32'h0);
        chk("ld_bubble_we", 32'(ow_tgt_gp_we), 32'h0);
        for (int i = 0; i < 3; i++) begin
            if (ow_stall) stalls++;
            tick();
        end
        chk("ld_req_held", 32'(or_mem_req), 32'h1);
        iw_mem_ack = 1'b1;
        #1;
        chk("ld_stall_ack", 32'(ow_stall), 32'h0);
        chk("ld_stall_cycles", 32'(stalls), 32'd4);
        tick();
        iw_mem_ack = 1'b0;
        chk("ld_result", 32'(ow_result), 32'hABCDEF);
        chk("ld_req_drop", 32'(or_mem_req), 32'h0);
        chk("ld_opc", 32'(ow_opc), 32'(`OPC_RU_LDu));
        chk("ld_gp_we", 32'(ow_tgt_gp_we), 32'h1);

        // STiu with immediate ack
        iw_opc = `OPC_IU_STiu; iw_addr = 24'h000010; iw_result = 24'h00005A; iw_tgt_gp_we = 1'b0;
        tick();
        chk("st_we", 32'(ow_mem_we), 32'h1);
        chk("st_wdata", 32'(ow_mem_wdata), 32'h00005A);
        chk("st_addr", 32'(ow_mem_addr), 32'h000010);
        iw_mem_ack = 1'b1;
        tick();
        iw_mem_ack = 1'b0;
        chk("st_result", 32'(ow_result), 32'h00005A);
        chk("st_req_drop", 32'(or_mem_req), 32'h0);
        chk("st_opc", 32'(ow_opc), 32'(`OPC_IU_STiu));

        // LDu with downstream stall over the ack
        iw_opc = `OPC_RU_LDu; iw_addr = 24'h000044; iw_result = '0; iw_tgt_gp_we = 1'b1;
        tick();
        iw_stall = 1'b1; iw_mem_ack = 1'b1; iw_mem_rdata = 24'hABCDEF;
        tick();
        iw_mem_ack = 1'b0; iw_mem_rdata = '0;
        chk("stl_result_hold0", 32'(ow_result), 32'h00005A);
        chk("stl_req_drop", 32'(or_mem_req), 32'h0);
        tick();
        chk("stl_result_hold1", 32'(ow_result), 32'h00005A);
        iw_stall = 1'b0;
        tick();
        chk("stl_result", 32'(ow_result), 32'hABCDEF);
        chk("stl_opc", 32'(ow_opc), 32'(`OPC_RU_LDu));

        // Ack in IDLE is ignored
        iw_opc = '0; iw_result = 24'h000777; iw_mem_ack = 1'b1; iw_mem_rdata = 24'h111111;
        tick();
        iw_mem_ack = 1'b0;
        chk("idle_ack_req", 32'(or_mem_req), 32'h0);
        chk("idle_ack_result", 32'(ow_result), 32'h000777);

        // Reset while a request is in flight
        iw_opc = `OPC_RU_LDu; iw_addr = 24'h000050;
        tick();
        chk("rr_req", 32'(or_mem_req), 32'h1);
        iw_rst = 1'b1;
        #1;
        chk("rr_req_async", 32'(or_mem_req), 32'h0);
        chk("rr_addr", 32'(ow_mem_addr), 32'h0);
        chk("rr_result", 32'(ow_result), 32'h0);
        tick();
        iw_rst = 1'b0; iw_opc = '0; iw_result = '0; iw_tgt_gp_we = 1'b0;
        iw_mem_ack = 1'b1; iw_mem_rdata = 24'hABCDEF;
        tick();
        iw_mem_ack = 1'b0;
        chk("rr_late_ack_req", 32'(or_mem_req), 32'h0);
        chk("rr_late_ack_result", 32'(ow_result), 32'h0);
        chk("rr_late_ack_opc", 32'(ow_opc), 32'h0);

`ifdef MEM_TIMEOUT_EN
        iw_opc = `OPC_RU_LDu; iw_addr = 24'h000060; iw_tgt_gp_we = 1'b1; iw_mem_rdata = 24'hABCDEF;
        tick();
        n = 0;
        while (or_mem_req && n < 40) begin
            n++;
            tick();
        end
        chk("to_cycles", 32'(n), 32'd16);
        chk("to_err", 32'(or_mem_err), 32'h1);
        chk("to_gp_we", 32'(ow_tgt_gp_we), 32'h0);
        chk("to_result", 32'(ow_result), 32'h0);
        iw_opc = '0;
        tick();
        chk("to_err_sticky", 32'(or_mem_err), 32'h1);
`else
        iw_opc = `OPC_RU_LDu; iw_addr = 24'h000060; iw_tgt_gp_we = 1'b1; iw_mem_rdata = 24'h00BEEF;
        tick();
        for (int i = 0; i < 20; i++) tick();
        chk("nto_req_wait", 32'(or_mem_req), 32'h1);
        chk("nto_err", 32'(or_mem_err), 32'h0);
        iw_mem_ack = 1'b1;
        tick();
        iw_mem_ack = 1'b0; iw_opc = '0;
        chk("nto_result", 32'(ow_result), 32'h00BEEF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
